divider_ctrl: RTL and testbench
===============================

# divider_ctrl

Control unit for the team's sequential restoring divider. It sequences the dividend, divisor and remainder registers and the shared subtractor through one division per `go` request, and reports completion, busy and divide-by-zero status. The block is purely control: datapath registers, comparator and subtractor live outside it and receive enables from it.

## Interface
- `WIDTH`, default 4: operand width, which is also the number of shift/subtract iterations; legal range is `WIDTH >= 2`.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `go`  in  1: start request; sampled only in IDLE.
- `abort`  in  1: cancels a division in progress.
- `dvsr_zero`  in  1: divisor register content equals 0 (datapath compare).
- `r_lt_y`  in  1: remainder register is less than divisor register (datapath compare).
- `ld_xy`  out  1: enable for loading dividend into X and divisor into Y.
- `clr_r`  out  1: clears remainder register R.
- `shl`  out  1: shifts the combined R:X left by one bit.
- `sub`  out  1: loads R ← R−Y and sets X[0] ← 1.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle completion pulse.
- `err`  out  1: one-cycle divide-by-zero pulse, coincident with `done`.

## Operation
- Internal iteration counter `cnt`, width $clog2(WIDTH+1).
- States and transitions:
  - IDLE: `go`=1 → LOAD; otherwise stay.
  - LOAD: `ld_xy`=1, `clr_r`=1, `cnt` ← WIDTH. Next state is CHECK (macro on) or SHIFT (macro off).
  - CHECK: `dvsr_zero`=1 → ERR; otherwise → SHIFT.
  - SHIFT: `shl`=1 → TEST.
  - TEST: `sub` = !`r_lt_y` (Mealy output); `cnt` ← `cnt`−1. If `cnt`==1 → DONE; otherwise → SHIFT.
  - DONE: `done`=1 → IDLE.
  - ERR: `done`=1, `err`=1 → IDLE.
- All outputs are decoded combinationally from the state; only `sub` also depends on an input.
- Every output is 0 whenever no state listed above drives it.
- `go` outside IDLE is ignored. No request queueing.
- `abort`=1 in LOAD, CHECK, SHIFT or TEST → IDLE on the next edge.
  - `done` and `err` are not pulsed.
  - `sub` is still decoded during that cycle if the state is TEST.
  - `abort` is ignored in IDLE, DONE and ERR.
- Priority: `rst` > `abort` > normal transitions.
- Reset values: state IDLE, `cnt` 0, every output 0. Reset mid-operation discards the division; the datapath contents are then don't-care.
- Unreachable state encodings → IDLE on the next edge.

## Timing
- Let E0 be the edge at which `go`=1 is sampled in IDLE. "After En" means the cycle following edge En.
- Macro on:
  - LOAD after E0, CHECK after E1.
  - Iteration k (1..WIDTH): SHIFT after E(2k), TEST after E(2k+1).
  - DONE after E(2·WIDTH+2). For WIDTH=4, `done` is high after E10.
  - ERR after E2.
- Macro off: every state from SHIFT onward is one cycle earlier. DONE is after E(2·WIDTH+1).
- `busy` rises after E0 and falls in the cycle after the DONE/ERR cycle.
- Back-to-back operation: with `go` held high, at least one IDLE cycle separates consecutive divisions.
- `dvsr_zero` is sampled in CHECK, one cycle after `ld_xy`, so Y is already valid.
- `r_lt_y` is sampled in TEST, one cycle after `shl`, so R is already valid.

## Configuration
- `DIVIDER_DIV_ZERO_CHECK_EN` defined:
  - CHECK and ERR states exist.
  - A zero divisor terminates the division after E2 with `err`=`done`=1, and `shl`/`sub` are never asserted.
- Not defined:
  - CHECK and ERR are compiled out. LOAD goes directly to SHIFT.
  - `dvsr_zero` is ignored and `err` is tied to 0.
  - A zero divisor runs all WIDTH iterations; with Y=0, `r_lt_y` is always 0, giving quotient all-ones and remainder equal to the dividend.

## Test plan
- WIDTH=4, macro on: 13/3 with a datapath model, `go` pulsed once.
  - `shl` pulses 4 times; `sub` asserts only in iteration 2 (r_lt_y pattern 1,0,1,1).
  - `done` is high after E10; model gives quotient 4, remainder 1; `busy` is high after E0 through E10.
- Macro on, divisor 0: `err`=`done`=1 after E2; `shl` and `sub` are never high; `busy` falls after E3.
- `abort`=1 in the TEST of iteration 2: state is IDLE after the next edge; `done`=`err`=0 throughout; a subsequent `go` gives 13/3 correctly.
- `rst`=1 for one edge while in SHIFT: all outputs 0 and IDLE next cycle; `go` asserted during reset is ignored.
- `go` held high for 30 cycles, 15/2: two full divisions each giving quotient 7, remainder 1; exactly one IDLE cycle between DONE and the next LOAD.
- Macro off, 9/0: no `err`; `done` after E9; `sub` asserted in all 4 iterations; model gives quotient 15, remainder 9.

Source files
------------

// File: rtl/divider_ctrl.sv
// divider_ctrl: sequencing FSM for a restoring divider datapath.
// Define DIVIDER_DIV_ZERO_CHECK_EN to add the divide-by-zero CHECK/ERR states.
module divider_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    input  logic abort,
    input  logic dvsr_zero,
    input  logic r_lt_y,
    output logic ld_xy,
    output logic clr_r,
    output logic shl,
    output logic sub,
    output logic busy,
    output logic done,
    output logic err
);
    localparam int CW = $clog2(WIDTH + 1);
`ifdef DIVIDER_DIV_ZERO_CHECK_EN
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, TEST, DONE, CHECK, ERR} state_t;
    localparam state_t AFTER_LOAD = CHECK;
`else
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, TEST, DONE} state_t;
    localparam state_t AFTER_LOAD = SHIFT;
    logic unused_dvsr_zero;
    assign unused_dvsr_zero = dvsr_zero;
`endif
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: state_d = go ? LOAD : IDLE;
            LOAD: begin
                cnt_d = CW'(WIDTH);
                state_d = abort ? IDLE : AFTER_LOAD;
            end
`ifdef DIVIDER_DIV_ZERO_CHECK_EN
            CHECK: state_d = abort ? IDLE : dvsr_zero ? ERR : SHIFT;
            ERR: state_d = IDLE;
`endif
            SHIFT: state_d = abort ? IDLE : TEST;
            TEST: begin
                cnt_d = cnt_q - 1'b1;
                state_d = abort ? IDLE : (cnt_q == CW'(1)) ? DONE : SHIFT;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
        end
    end
    assign ld_xy = state_q == LOAD;
    assign clr_r = state_q == LOAD;
    assign shl = state_q == SHIFT;
    assign sub = (state_q == TEST) && !r_lt_y;
    assign busy = state_q != IDLE;
`ifdef DIVIDER_DIV_ZERO_CHECK_EN
    assign err = state_q == ERR;
    assign done = (state_q == DONE) || (state_q == ERR);
`else
    assign err = 1'b0;
    assign done = state_q == DONE;
`endif
endmodule

// File: tb/tb_divider_ctrl.sv
// tb_divider_ctrl: drives divider_ctrl against a behavioural datapath and
// checks quotient/remainder, cycle timing, abort and reset behaviour.
module tb_divider_ctrl;
    localparam int W = 4;
`ifdef DIVIDER_DIV_ZERO_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, go = 1'b0, abort = 1'b0;
    logic ld_xy, clr_r, shl, sub, busy, done, err, dvsr_zero, r_lt_y;
    logic [W-1:0] dv_a = '0, dv_b = '0, x_q = '0, y_q = '0;
    logic [W:0] r_q = '0;
    int tests = 0, failed = 0;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    divider_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .go(go), .abort(abort),
        .dvsr_zero(dvsr_zero), .r_lt_y(r_lt_y),
        .ld_xy(ld_xy), .clr_r(clr_r), .shl(shl), .sub(sub),
        .busy(busy), .done(done), .err(err)
    );

    // Datapath registers that the controller steers; R is one bit wider than X.
    assign dvsr_zero = (y_q == '0);
    assign r_lt_y = r_q < {1'b0, y_q};
    always @(posedge clk) begin
        if (ld_xy) begin
            x_q <= dv_a;
            y_q <= dv_b;
        end
        if (clr_r) r_q <= '0;
        if (shl) begin
            r_q <= {r_q[W-1:0], x_q[W-1]};
            x_q <= {x_q[W-2:0], 1'b0};
        end
        if (sub) begin
            r_q <= r_q - {1'b0, y_q};
            x_q[0] <= 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int req);
        tests++;
        if (act != req) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic do_div(input int a, input int b, input int eq, input int er, input string nm);
        int n = 0, shls = 0, qo = 0, lows = 0, early = 0;
        bit zerr = CHK && (b == 0);
        int en = zerr ? 2 : (CHK ? 2 * W + 2 : 2 * W + 1);
        dv_a = a[W-1:0];
        dv_b = b[W-1:0];
        go = 1'b1;
        step();
        go = 1'b0;
        while (!done && n < 60) begin
            if (!busy) lows++;
            if (err) early++;
            if (shl) shls++;
            if (sub) qo |= 1 << (W - shls);
            step();
            n++;
        end
        chk({nm, " done_cycle"}, n, en);
        chk({nm, " err_at_done"}, int'(err), int'(zerr));
        chk({nm, " err_before_done"}, early, 0);
        chk({nm, " busy_low_during"}, lows, 0);
        chk({nm, " shl_count"}, shls, zerr ? 0 : W);
        chk({nm, " sub_pattern"}, qo, zerr ? 0 : eq);
        if (!zerr) begin
            chk({nm, " quotient"}, int'(x_q), eq);
            chk({nm, " remainder"}, int'(r_q), er);
        end
        step();
        chk({nm, " idle_after"}, int'({busy, done, err, ld_xy}), 0);
    endtask

    initial begin
        int bad, ndone, last_done, n;
        vecs[0] = '{13, 3, 4, 1};
        vecs[1] = '{15, 2, 7, 1};
        vecs[2] = '{9, 1, 9, 0};
        vecs[3] = '{0, 5, 0, 0};
        vecs[4] = '{7, 9, 0, 7};
        vecs[5] = '{15, 15, 1, 0};
        vecs[6] = '{8, 3, 2, 2};
        vecs[7] = '{9, 0, 15, 9};

        rst = 1'b1;
        go = 1'b1;
        step();
        step();
        chk("reset_outputs", int'({ld_xy, clr_r, shl, sub, busy, done, err}), 0);
        rst = 1'b0;
        go = 1'b0;
        step();
        chk("reset_idle", int'(busy), 0);

        foreach (vecs[i]) do_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, $sformatf("vec%0d", i));

        // Abort in TEST of iteration 2 (sub is high there for 13/3).
        dv_a = 13;
        dv_b = 3;
        go = 1'b1;
        step();
        go = 1'b0;
        bad = 0;
        for (int i = 0; i < (CHK ? 5 : 4); i++) begin
            if (done || err) bad++;
            step();
        end
        chk("abort_test_sub", int'({busy, sub}), 3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_idle", int'({busy, done, err}), 0);
        step();
        chk("abort_no_pulse", bad + int'({busy, done, err}), 0);
        do_div(13, 3, 4, 1, "post_abort");

        // Abort is ignored in IDLE but honoured in LOAD.
        abort = 1'b1;
        go = 1'b1;
        step();
        go = 1'b0;
        chk("idle_abort_ignored", int'(ld_xy), 1);
        step();
        abort = 1'b0;
        chk("load_abort", int'({busy, done, err}), 0);

        // Reset while in SHIFT, with go held during reset.
        dv_a = 13;
        dv_b = 3;
        go = 1'b1;
        step();
        go = 1'b0;
        for (int i = 0; i < (CHK ? 2 : 1); i++) step();
        chk("rst_in_shift_pre", int'(shl), 1);
        rst = 1'b1;
        go = 1'b1;
        step();
        chk("rst_in_shift_outs", int'({ld_xy, clr_r, shl, sub, busy, done, err}), 0);
        rst = 1'b0;
        go = 1'b0;
        step();
        chk("rst_go_ignored", int'(busy), 0);

        // Back-to-back with go held high for 30 cycles, 15/2.
        dv_a = 15;
        dv_b = 2;
        go = 1'b1;
        step();
        ndone = 0;
        last_done = -1;
        for (int i = 0; i < 30; i++) begin
            if (done) begin
                ndone++;
                last_done = i;
                chk("b2b_quotient", int'(x_q), 7);
                chk("b2b_remainder", int'(r_q), 1);
            end
            if (ld_xy && last_done >= 0) chk("b2b_gap", i - last_done, 2);
            step();
        end
        go = 1'b0;
        chk("b2b_done_count", ndone, 2);
        n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
        chk("b2b_drain", int'(busy), 0);

        // Random divisions checked against plain integer arithmetic.
        for (int i = 0; i < 30; i++) begin
            int a = $urandom_range(0, 15);
            int b = $urandom_range(0, 15);
            do_div(a, b, b != 0 ? a / b : 15, b != 0 ? a % b : a, $sformatf("rnd%0d_%0d/%0d", i, a, b));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
